div_ctrl: RTL and testbench

- Sequencing controller between the EXU issue logic and the iterative radix-2 divider.
- Decodes the RV64M divide ops (DIV/DIVU/REM/REMU, plus W variants).
- Resolves divide-by-zero and signed overflow in a fast path without starting the divider; otherwise launches the divider, waits for completion and selects quotient or remainder.
- Sign-extends W results and holds the final result behind a valid/ready handshake to writeback.

---
 rtl/div_ctrl_if.sv | 25 ++
 rtl/div_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_div_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Issue/writeback handshake bundle between the EXU and div_ctrl.
// slave = controller side, master = issue/writeback side.
interface div_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             i_valid;
   logic             o_ready;
   logic [1:0]       i_op;
   logic             i_word;
   logic [WIDTH-1:0] i_src1;
   logic [WIDTH-1:0] i_src2;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;

   modport slave (
      input  i_valid, i_op, i_word, i_src1, i_src2, i_ready,
      output o_ready, o_valid, o_result
   );

   modport master (
      output i_valid, i_op, i_word, i_src1, i_src2, i_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/div_ctrl.sv
// RV64M divide sequencer: fast path for divide-by-zero/overflow, otherwise drives the radix-2 divider.
// Optional one-entry result cache enabled by defining DIV_CTRL_CACHE_EN.
module div_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   div_ctrl_if.slave        req,
   output logic             o_div_start,
   output logic             o_div_flush,
   output logic             o_div_divw,
   output logic             o_div_signed,
   output logic [WIDTH-1:0] o_div_dividend,
   output logic [WIDTH-1:0] o_div_divisor,
   input  logic             i_div_busy,
   input  logic             i_div_end_valid,
   output logic             o_div_end_ready,
   input  logic [WIDTH-1:0] i_div_quotient,
   input  logic [WIDTH-1:0] i_div_remainder
);
   localparam int HW = WIDTH / 2;
   localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [HW-1:0]    MIN_HALF = {1'b1, {(HW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;

   state_e           state_q;
   logic [1:0]       op_q;
   logic             word_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divisor_q;
   logic [WIDTH-1:0] result_q;
   logic             valid_q;
   logic             start_q;

   logic             accept;
   logic             div_zero;
   logic             overflow;
   logic             cache_hit;
   logic             fast;
   logic [WIDTH-1:0] fast_quo;
   logic [WIDTH-1:0] fast_rem;
   logic [WIDTH-1:0] fast_res_d;
   logic [WIDTH-1:0] div_res_d;

   function automatic logic [WIDTH-1:0] fmt_res(input logic word, input logic [WIDTH-1:0] v);
      return word ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
   endfunction

`ifdef DIV_CTRL_CACHE_EN
   logic             cache_vld_q;
   logic             cache_signed_q;
   logic             cache_word_q;
   logic [WIDTH-1:0] cache_a_q;
   logic [WIDTH-1:0] cache_b_q;
   logic [WIDTH-1:0] cache_quo_q;
   logic [WIDTH-1:0] cache_rem_q;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      accept     = 1'b0;
      div_zero   = 1'b0;
      overflow   = 1'b0;
      cache_hit  = 1'b0;
      fast_quo   = '0;
      fast_rem   = '0;

      accept = (state_q == S_IDLE) && !i_div_busy && req.i_valid;
      if (req.i_word) begin
         div_zero = (req.i_src2[HW-1:0] == '0);
         overflow = !req.i_op[0] && (req.i_src1[HW-1:0] == MIN_HALF)
                    && (req.i_src2[HW-1:0] == '1);
      end else begin
         div_zero = (req.i_src2 == '0);
         overflow = !req.i_op[0] && (req.i_src1 == MIN_FULL) && (req.i_src2 == '1);
      end

`ifdef DIV_CTRL_CACHE_EN
      cache_hit = cache_vld_q && (cache_signed_q == !req.i_op[0])
                  && (cache_word_q == req.i_word)
                  && (cache_a_q == req.i_src1) && (cache_b_q == req.i_src2);
`endif

      if (div_zero) begin
         fast_quo = '1;
         fast_rem = req.i_src1;
      end else if (overflow) begin
         fast_quo = req.i_src1;
         fast_rem = '0;
`ifdef DIV_CTRL_CACHE_EN
      end else if (cache_hit) begin
         fast_quo = cache_quo_q;
         fast_rem = cache_rem_q;
`endif
      end

      fast       = div_zero || overflow || cache_hit;
      fast_res_d = fmt_res(req.i_word, req.i_op[1] ? fast_rem : fast_quo);
      div_res_d  = fmt_res(word_q, op_q[1] ? i_div_remainder : i_div_quotient);
   end

   // NOTE: state registers use non-blocking assignments; the reset is synchronous, so it sits inside the clocked branch.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         word_q     <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         start_q    <= 1'b0;
      end else if (i_flush) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q       <= req.i_op;
                  word_q     <= req.i_word;
                  dividend_q <= req.i_src1;
                  divisor_q  <= req.i_src2;
                  if (fast) begin
                     result_q <= fast_res_d;
                     valid_q  <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= S_START;
                  end
               end
            end
            S_START: begin
               start_q <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (i_div_end_valid) begin
                  result_q <= div_res_d;
                  valid_q  <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               if (req.i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DIV_CTRL_CACHE_EN
   logic cache_wr;
   assign cache_wr = i_rst_n && !i_flush && (state_q == S_WAIT) && i_div_end_valid;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cache_vld_q <= 1'b0;
      end else if (cache_wr) begin
         cache_vld_q <= 1'b1;
      end
   end

   // NOTE: the entry payload is storage only ever read behind cache_vld_q, so it carries no reset.
   always_ff @(posedge i_clk) begin
      if (cache_wr) begin
         cache_signed_q <= !op_q[0];
         cache_word_q   <= word_q;
         cache_a_q      <= dividend_q;
         cache_b_q      <= divisor_q;
         cache_quo_q    <= i_div_quotient;
         cache_rem_q    <= i_div_remainder;
      end
   end
`endif

   assign req.o_ready     = (state_q == S_IDLE) && !i_div_busy;
   assign req.o_valid     = valid_q;
   assign req.o_result    = result_q;
   assign o_div_start     = start_q;
   assign o_div_flush     = i_flush;
   assign o_div_divw      = word_q;
   assign o_div_signed    = !op_q[0];
   assign o_div_dividend  = dividend_q;
   assign o_div_divisor   = divisor_q;
   assign o_div_end_ready = (state_q == S_WAIT);
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency divider.
// Expected latencies/start counts follow DIV_CTRL_CACHE_EN when it is defined.
module tb_div_ctrl;
   localparam int W = 64;

`ifdef DIV_CTRL_CACHE_EN
   localparam int HIT_STARTS = 0;
   localparam int HIT_LAT    = 1;
`else
   localparam int HIT_STARTS = 1;
   localparam int HIT_LAT    = 8;
`endif
   localparam int SLOW_LAT = 8;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   div_ctrl_if #(.WIDTH(W)) bus ();

   logic         div_start, div_flush, div_divw, div_signed;
   logic [W-1:0] div_dividend, div_divisor;
   logic         div_busy, div_end_valid, div_end_ready;
   logic [W-1:0] div_quo, div_rem;

   int   n_cmp = 0;
   int   n_err = 0;
   int   start_cnt = 0;
   int   dcnt = 0;
   logic last_signed = 1'b0;
   logic last_divw = 1'b0;

   div_ctrl #(.WIDTH(W)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_flush         (flush),
      .req             (bus),
      .o_div_start     (div_start),
      .o_div_flush     (div_flush),
      .o_div_divw      (div_divw),
      .o_div_signed    (div_signed),
      .o_div_dividend  (div_dividend),
      .o_div_divisor   (div_divisor),
      .i_div_busy      (div_busy),
      .i_div_end_valid (div_end_valid),
      .o_div_end_ready (div_end_ready),
      .i_div_quotient  (div_quo),
      .i_div_remainder (div_rem)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model_div(input logic sgn, input logic word,
                                               input logic [63:0] a, input logic [63:0] b);
      logic [63:0] q, r;
      logic [31:0] q32, r32;
      int          sa, sb;
      longint      la, lb;
      if (word) begin
         sa = a[31:0];
         sb = b[31:0];
         if (b[31:0] == 32'h0) begin
            q32 = '1; r32 = a[31:0];
         end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
            q32 = a[31:0]; r32 = '0;
         end else if (sgn) begin
            q32 = sa / sb; r32 = sa % sb;
         end else begin
            q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
         end
         q = {{32{q32[31]}}, q32};
         r = {{32{r32[31]}}, r32};
      end else begin
         la = a;
         lb = b;
         if (b == 64'h0) begin
            q = '1; r = a;
         end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = '0;
         end else if (sgn) begin
            q = la / lb; r = la % lb;
         end else begin
            q = a / b; r = a % b;
         end
      end
      return {q, r};
   endfunction

   // Divider stand-in: result 5 edges after the start pulse, held until consumed.
   always @(posedge clk) begin
      if (!rst_n || div_flush) begin
         div_busy      <= 1'b0;
         div_end_valid <= 1'b0;
         dcnt          <= 0;
      end else if (div_start) begin
         start_cnt          <= start_cnt + 1;
         last_signed        <= div_signed;
         last_divw          <= div_divw;
         {div_quo, div_rem} <= model_div(div_signed, div_divw, div_dividend, div_divisor);
         div_busy           <= 1'b1;
         dcnt               <= 5;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) div_end_valid <= 1'b1;
      end else if (div_end_valid && div_end_ready) begin
         div_end_valid <= 1'b0;
         div_busy      <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int exp_starts, input int exp_lat, input int hold);
      int s0, cyc;
      @(negedge clk);
      check({tag, ":ready"}, 64'(bus.o_ready), 64'd1);
      s0 = start_cnt;
      bus.i_valid = 1'b1; bus.i_op = op; bus.i_word = word;
      bus.i_src1 = a; bus.i_src2 = b;
      @(negedge clk);
      bus.i_valid = 1'b0;
      cyc = 1;
      while (!bus.o_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ":valid"}, 64'(bus.o_valid), 64'd1);
      check({tag, ":lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, ":starts"}, 64'(start_cnt - s0), 64'(exp_starts));
      check({tag, ":result"}, bus.o_result, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ":hold_result"}, bus.o_result, exp);
         check({tag, ":hold_valid"}, 64'(bus.o_valid), 64'd1);
         check({tag, ":hold_ready"}, 64'(bus.o_ready), 64'd0);
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_ready = 1'b0;
      check({tag, ":drop"}, 64'(bus.o_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      bus.i_valid = 1'b0; bus.i_op = '0; bus.i_word = 1'b0;
      bus.i_src1 = '0; bus.i_src2 = '0; bus.i_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst:valid", 64'(bus.o_valid), 64'd0);
      check("rst:result", bus.o_result, 64'd0);
      check("rst:start", 64'(div_start), 64'd0);
      check("rst:dividend", div_dividend, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst:ready", 64'(bus.o_ready), 64'd1);

      run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1, SLOW_LAT, 0);
      check("divu:signed", 64'(last_signed), 64'd0);
      run_op("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, HIT_STARTS, HIT_LAT, 0);

      run_op("div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFD, 1, SLOW_LAT, 0);
      check("div:signed", 64'(last_signed), 64'd1);
      run_op("rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, HIT_STARTS, HIT_LAT, 0);

      run_op("divu_by0", OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
      run_op("remu_by0", OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 0, 1, 0);

      run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 0, 1, 0);
      run_op("remw_ovf", OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 0, 1, 0);

      run_op("divw_m8_2", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF8, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFC, 1, SLOW_LAT, 0);
      check("divw:divw", 64'(last_divw), 64'd1);

      // Flush while the divider is mid-operation.
      @(negedge clk);
      s0 = start_cnt;
      bus.i_valid = 1'b1; bus.i_op = OP_DIVU; bus.i_word = 1'b0;
      bus.i_src1 = 64'd50; bus.i_src2 = 64'd5;
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("flush:started", 64'(start_cnt - s0), 64'd1);
      check("flush:div_flush_lo", 64'(div_flush), 64'd0);
      flush = 1'b1;
      #1;
      check("flush:div_flush_hi", 64'(div_flush), 64'd1);
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("flush:no_valid", 64'(bus.o_valid), 64'd0);
      end
      check("flush:ready", 64'(bus.o_ready), 64'd1);

      // Flush and request in the same cycle: request is dropped.
      @(negedge clk);
      s0 = start_cnt;
      bus.i_valid = 1'b1; bus.i_op = OP_DIVU; bus.i_src1 = 64'd20; bus.i_src2 = 64'd0;
      flush = 1'b1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      flush = 1'b0;
      repeat (3) @(negedge clk);
      check("flushacc:no_valid", 64'(bus.o_valid), 64'd0);
      check("flushacc:no_start", 64'(start_cnt - s0), 64'd0);
      check("flushacc:ready", 64'(bus.o_ready), 64'd1);

      run_op("divu_9_3_hold", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 1, SLOW_LAT, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
